// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and a show-ahead
// receive FIFO. It feeds buffered bytes, status flags and a pop strobe to the
// ACIA register block.
// Optional feature macro: UART_RX_PARITY_EN. When defined, frames are 8E1,
// a PARITY state sits between DATA and STOP, and bytes with bad parity are
// dropped and flagged on the sticky par_err output.
module uart_rx_fifo #(
    parameter int BAUD_DIV = 26,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic               rd,
    input  logic               err_clr,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    output logic               rx_full,
    output logic [FIFO_AW:0]   rx_count,
    output logic               ovr_err,
`ifdef UART_RX_PARITY_EN
    output logic               par_err,
`endif
    output logic               frm_err
);

    localparam int TW    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [TW-1:0] TICK_MAX = TW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    logic [1:0]        sync_q, sync_d;
    logic              rxs;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;
    state_t            state_q, state_d;
    logic [3:0]        sub_q, sub_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              push;
    logic              frm_set;
    logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]  rd_ptr_q, rd_ptr_d;
    logic              ovr_q, ovr_d;
    logic              frm_q, frm_d;
    logic              empty, full, pop, wr_en, ovr_set;
    logic [7:0]        mem [0:DEPTH-1];
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              par_q, par_d;
    logic              par_set;
`endif

    assign sync_d     = {sync_q[0], rx};
    assign rxs        = sync_q[1];
    assign tick       = (tick_cnt_q == TICK_MAX);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // Receive FSM next-state: start detect, mid-bit sampling, stop/break handling
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        frm_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    sub_d   = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (sub_q == 4'd7) begin
                        if (rxs) begin
                            state_d = IDLE;             // glitch, not a real start bit
                        end else begin
                            sub_d   = 4'd0;
                            bit_d   = 3'd0;
                            state_d = DATA;
                        end
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        shift_d = {rxs, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        // Even parity: data ones plus parity bit must be even
                        par_bad_d = ^{shift_q, rxs};
                        par_set   = ^{shift_q, rxs};
                        state_d   = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        if (rxs) begin
`ifdef UART_RX_PARITY_EN
                            push = !par_bad_q;
`else
                            push = 1'b1;
`endif
                            state_d = IDLE;
                        end else begin
                            frm_set = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer and sticky-flag next-state; same-cycle pop makes room for a push
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        pop      = rd && !empty;
        wr_en    = push && (!full || pop);
        ovr_set  = push && full && !pop;
        wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(pop);
        ovr_d    = ovr_set | (ovr_q & ~err_clr);
        frm_d    = frm_set | (frm_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
        par_d    = par_set | (par_q & ~err_clr);
`endif
    end

    // State registers; reset abandons any frame and empties the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            sub_q      <= 4'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovr_q      <= ovr_d;
            frm_q      <= frm_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            par_q      <= par_d;
`endif
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
        end
    end

    // Show-ahead head read, forced to zero while the FIFO is empty
    assign rx_data  = empty ? 8'h00 : mem[rd_ptr_q[FIFO_AW-1:0]];
    assign rx_valid = !empty;
    assign rx_full  = full;
    assign rx_count = wr_ptr_q - rd_ptr_q;
    assign ovr_err  = ovr_q;
    assign frm_err  = frm_q;
`ifdef UART_RX_PARITY_EN
    assign par_err  = par_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at BAUD_DIV=4 (64 clk/bit),
// FIFO_AW=4. Inputs change on the falling edge; outputs are checked there too.
module tb_uart_rx_fifo;

    localparam int BD  = 4;
    localparam int AW  = 4;
    localparam int CPB = 16 * BD;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        rd;
    logic        err_clr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_full;
    logic [AW:0] rx_count;
    logic        ovr_err;
    logic        frm_err;
`ifdef UART_RX_PARITY_EN
    logic        par_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int meas     = 0;

    uart_rx_fifo #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rd       (rd),
        .err_clr  (err_clr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_full  (rx_full),
        .rx_count (rx_count),
        .ovr_err  (ovr_err),
`ifdef UART_RX_PARITY_EN
        .par_err  (par_err),
`endif
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame starting on a tick-aligned cycle; rd is pulsed at offset rd_at.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic bad_par, input int rd_at);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, (^b) ^ bad_par, b, 1'b0};
`else
        bits = {1'b0, stop_bit, b, 1'b0};
`endif
        @(negedge clk);
        while (cyc % BD != 0) @(negedge clk);
        for (int n = 0; n < NBITS * CPB; n++) begin
            if (n != 0) @(negedge clk);
            if (meas < 0 && rx_count == 5'd16) meas = n;
            rx = bits[4'(n / CPB)];
            rd = (n == rd_at);
        end
        @(negedge clk);
        rd = 1'b0;
        $display("frame data=0x%02h stop=%0b badpar=%0b rd_at=%0d", b, stop_bit, bad_par, rd_at);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; rd = 1'b0; err_clr = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_full",  32'(rx_full),  0);
        check("rst_count", 32'(rx_count), 0);
        check("rst_ovr",   32'(ovr_err),  0);
        check("rst_frm",   32'(frm_err),  0);
        check("rst_data",  32'(rx_data),  0);
        reset = 1'b0;
        idle(20);

        // Single byte 0x55
        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle(40);
        check("b55_valid", 32'(rx_valid), 1);
        check("b55_data",  32'(rx_data),  32'h55);
        check("b55_count", 32'(rx_count), 1);
        check("b55_ovr",   32'(ovr_err),  0);
        check("b55_frm",   32'(frm_err),  0);
        pop();
        check("b55_popped", 32'(rx_valid), 0);

        // 8-clk glitch on rx is rejected at mid start bit
        @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        idle(200);
        check("glitch_valid", 32'(rx_valid), 0);
        check("glitch_frm",   32'(frm_err),  0);

        // Framing error followed by a long break, then a clean frame
        send_frame(8'hA3, 1'b0, 1'b0, -1);
        repeat (200) @(negedge clk);
        idle(100);
        check("frm_set",   32'(frm_err),  1);
        check("frm_empty", 32'(rx_valid), 0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(40);
        check("b3c_data",  32'(rx_data),  32'h3C);
        check("b3c_count", 32'(rx_count), 1);
        clear_errs();
        check("frm_clr", 32'(frm_err), 0);
        pop();

        // 17 bytes without reads: last one overruns
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
        idle(40);
        check("ovr_full",  32'(rx_full),  1);
        check("ovr_count", 32'(rx_count), 16);
        check("ovr_set",   32'(ovr_err),  1);
        for (int i = 0; i < 16; i++) begin
            check("ovr_pop_data", 32'(rx_data), 32'(i));
            pop();
        end
        check("ovr_drained", 32'(rx_valid), 0);
        check("ovr_still",   32'(ovr_err),  1);
        clear_errs();
        check("ovr_clr", 32'(ovr_err), 0);

        // rd while empty has no effect
        pop();
        pop();
        check("rdempty_count", 32'(rx_count), 0);
        check("rdempty_valid", 32'(rx_valid), 0);

        // Fill to 16, locating the push cycle, then pop on the push cycle when full
        for (int i = 0; i < 15; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b0, -1);
        meas = -1;
        send_frame(8'h2F, 1'b1, 1'b0, -1);
        check("push_cycle_found", 32'(meas >= 1), 1);
        send_frame(8'h30, 1'b1, 1'b0, meas - 1);
        idle(40);
        check("pp_count", 32'(rx_count), 16);
        check("pp_full",  32'(rx_full),  1);
        check("pp_ovr",   32'(ovr_err),  0);
        for (int i = 0; i < 16; i++) begin
            check("pp_pop_data", 32'(rx_data), 32'(8'h21 + i));
            pop();
        end
        check("pp_drained", 32'(rx_valid), 0);

        // Asynchronous reset in the middle of a data bit
        send_frame(8'h11, 1'b1, 1'b0, -1);
        idle(20);
        check("pre_rst_count", 32'(rx_count), 1);
        rx = 1'b0;
        repeat (CPB + 100) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_full",  32'(rx_full),  0);
        check("mid_rst_count", 32'(rx_count), 0);
        check("mid_rst_ovr",   32'(ovr_err),  0);
        check("mid_rst_frm",   32'(frm_err),  0);
        check("mid_rst_data",  32'(rx_data),  0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(50);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        idle(40);
        check("b7e_data",  32'(rx_data),  32'h7E);
        check("b7e_count", 32'(rx_count), 1);
        check("b7e_frm",   32'(frm_err),  0);
        pop();
`ifdef UART_RX_PARITY_EN
        check("par_clean", 32'(par_err), 0);
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        idle(40);
        check("par_set",   32'(par_err),  1);
        check("par_count", 32'(rx_count), 0);
        clear_errs();
        check("par_clr", 32'(par_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
